t03_spi_master: RTL and testbench

//  SPI master (mode 0: CPOL=0, CPHA=0) directly downstream of the memory-mapped IO block.
//  - Consumes the SPI output register and the clock-divider register, plus a start strobe

---
 rtl/t03_spi_pkg.sv | 15 +
 rtl/t03_spi_if.sv | 21 ++
 rtl/t03_spi_halfcnt.sv | 33 +++
 rtl/t03_spi_master.sv | 118 +++++++++++
 tb/tb_t03_spi_master.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/t03_spi_pkg.sv
// Shared types and constants for the t03 SPI master slice.
package t03_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TAIL  = 3'd4
  } spi_state_e;

  localparam int BUSY_BIT = 31;
  localparam int DONE_BIT = 30;

endpackage

// File: rtl/t03_spi_if.sv
// Bus between the memory-mapped IO block, the SPI master and the SPI pins.
interface t03_spi_if;
  logic        start;
  logic [31:0] tx_word;
  logic [31:0] clkdiv;
  logic [31:0] rd_word;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;

  modport master (
    input  start, tx_word, clkdiv, miso,
    output rd_word, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_word, clkdiv, miso,
    input  rd_word, sclk, mosi, cs_n
  );
endinterface

// File: rtl/t03_spi_halfcnt.sv
// Half-period down-counter: ticks on the last clk of each SCLK half-period.
module t03_spi_halfcnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_h,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_h;
  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == DIV_W'(1));

  // H is captured here on load so later divider writes cannot stretch a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_h   <= i_h;
      r_cnt <= i_h;
    end else if (o_tick) begin
      r_cnt <= r_h;
    end else if (i_en) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/t03_spi_master.sv
// Mode-0 SPI master: shifts one MSB-first frame per accepted start and
// reports busy/done plus the last received frame on rd_word.
module t03_spi_master
  import t03_spi_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int DIV_W      = 16
) (
  input  logic clk,
  input  logic rst,
  t03_spi_if.master bus
);

  localparam int BW = $clog2(FRAME_BITS + 1);

  spi_state_e            r_state;
  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_data;
  logic [BW-1:0]         r_bits;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;

  logic                  w_load;
  logic                  w_en;
  logic                  w_tick;
  logic [DIV_W-1:0]      w_h;
  logic [FRAME_BITS:0]   w_tx_sh;
  logic [FRAME_BITS:0]   w_rx_sh;
  logic [31:0]           w_rd;
  logic                  w_unused;

  assign w_h     = (bus.clkdiv[DIV_W-1:0] == '0) ? DIV_W'(1) : bus.clkdiv[DIV_W-1:0];
  assign w_load  = (r_state == ST_IDLE) && bus.start;
  assign w_en    = (r_state != ST_IDLE);
  // one-bit-wider shifts keep FRAME_BITS=1 legal
  assign w_tx_sh = {r_tx, 1'b0};
  assign w_rx_sh = {r_rx, bus.miso};
  assign w_unused = ^{bus.clkdiv[31:DIV_W], bus.tx_word[31:FRAME_BITS]};

  t03_spi_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_en),
    .i_h    (w_h),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx    <= '0;
      r_rx    <= '0;
      r_data  <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_tx    <= bus.tx_word[FRAME_BITS-1:0];
          r_rx    <= '0;
          r_bits  <= BW'(FRAME_BITS);
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_cs_n  <= 1'b0;
          r_mosi  <= bus.tx_word[FRAME_BITS-1];
          r_state <= ST_SETUP;
        end
        ST_SETUP, ST_LOW: if (w_tick) begin
          r_sclk  <= 1'b1;
          r_state <= ST_HIGH;
        end
        ST_HIGH: if (w_tick) begin
          r_rx   <= w_rx_sh[FRAME_BITS-1:0];
          r_sclk <= 1'b0;
          if (r_bits == BW'(1)) begin
            r_state <= ST_TAIL;
          end else begin
            r_tx    <= w_tx_sh[FRAME_BITS-1:0];
            r_mosi  <= w_tx_sh[FRAME_BITS-1];
            r_bits  <= r_bits - BW'(1);
            r_state <= ST_LOW;
          end
        end
        ST_TAIL: if (w_tick) begin
          r_cs_n  <= 1'b1;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_data  <= r_rx;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd                   = '0;
    w_rd[FRAME_BITS-1:0]   = r_data;
    w_rd[BUSY_BIT]         = r_busy;
    w_rd[DONE_BIT]         = r_done;
  end

  assign bus.rd_word = w_rd;
  assign bus.sclk    = r_sclk;
  assign bus.mosi    = r_mosi;
  assign bus.cs_n    = r_cs_n;

endmodule

// File: tb/tb_t03_spi_master.sv
// Scoreboard bench for t03_spi_master: frames are predicted at issue time and
// checked by a pin-level monitor when chip select rises.
module tb_t03_spi_master;

  localparam int F = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  t03_spi_if bus ();

  t03_spi_master #(.FRAME_BITS(F), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          cs_low;
    logic [7:0]  mosi;
    int          h;
  } exp_t;

  exp_t       exq[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] reply  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // SPI slave: presents reply MSB first, advancing after each SCLK fall
  initial begin
    int sidx;
    bus.miso = 1'b0;
    forever begin
      @(negedge bus.cs_n);
      sidx = F - 1;
      bus.miso = reply[sidx];
      while (bus.cs_n === 1'b0) begin
        @(negedge bus.sclk or posedge bus.cs_n);
        if (bus.cs_n === 1'b0 && sidx > 0) begin
          sidx--;
          bus.miso = reply[sidx];
        end
      end
    end
  end

  // Monitor: measures each frame at the pins, compares at cs_n rise
  logic        p_cs = 1'b1, p_sclk = 1'b0;
  int          cs_cnt, run, nrise, rmin, rmax;
  logic [7:0]  got;
  logic        b_ok, d_ok;
  logic [29:0] d0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      p_cs   = 1'b1;
      p_sclk = 1'b0;
    end else begin
      if (p_cs && !bus.cs_n) begin
        cs_cnt = 0; run = 0; nrise = 0; got = '0;
        rmin = 1 << 30; rmax = 0; b_ok = 1'b1; d_ok = 1'b1;
        d0 = bus.rd_word[29:0];
      end
      if (!bus.cs_n) begin
        cs_cnt++;
        if (!p_cs && bus.sclk != p_sclk) begin
          if (run < rmin) rmin = run;
          if (run > rmax) rmax = run;
          run = 0;
        end
        run++;
        if (!p_sclk && bus.sclk) begin
          got = {got[6:0], bus.mosi};
          nrise++;
        end
        if (bus.rd_word[31] !== 1'b1) b_ok = 1'b0;
        if (bus.rd_word[29:0] !== d0) d_ok = 1'b0;
      end
      if (!p_cs && bus.cs_n) begin
        if (run < rmin) rmin = run;
        if (run > rmax) rmax = run;
        if (exq.size() == 0) begin
          n_chk++;
          $display("FAIL frame_unexpected: got frame mosi=%h rd_word=%h expected no frame", got, bus.rd_word);
        end else begin
          e = exq.pop_front();
          chk("rd_word", bus.rd_word, e.rd);
          chk("cs_low_cycles", cs_cnt, e.cs_low);
          chk("mosi_bits", {24'h0, got}, {24'h0, e.mosi});
          chk("sclk_rises", nrise, F);
          chk("half_min", rmin, e.h);
          chk("half_max", rmax, e.h);
          chk("busy_held", {31'h0, b_ok}, 32'd1);
          chk("data_stable", {31'h0, d_ok}, 32'd1);
        end
      end
      p_cs   = bus.cs_n;
      p_sclk = bus.sclk;
    end
  end

  // Called and returns at posedge+#1
  task automatic send(input logic [31:0] tx, input logic [31:0] div,
                      input logic [7:0] rep, input bit push);
    int   h;
    int   t;
    exp_t x;
    t = 0;
    while (bus.rd_word[31] !== 1'b0 && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 5000) begin
      n_chk++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles expected 0", bus.rd_word[31], t);
    end
    h = (div[15:0] == 16'h0) ? 1 : int'(div[15:0]);
    reply       = rep;
    bus.tx_word = tx;
    bus.clkdiv  = div;
    if (push) begin
      x.rd     = 32'h4000_0000 | {24'h0, rep};
      x.cs_low = (2 * F + 1) * h;
      x.mosi   = tx[7:0];
      x.h      = h;
      exq.push_back(x);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", {30'h0, bus.rd_word[31:30]}, 32'd2);
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nr;
    int t;
    logic ps;
    bus.start   = 1'b0;
    bus.tx_word = '0;
    bus.clkdiv  = 32'd1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cs_n", {31'h0, bus.cs_n}, 32'd1);
    chk("reset_sclk", {31'h0, bus.sclk}, 32'd0);
    chk("reset_mosi", {31'h0, bus.mosi}, 32'd0);
    chk("reset_rd_word", bus.rd_word, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(32'h0000_00A5, 32'd1, 8'h3C, 1'b1);
    send(32'hFFFF_FF5A, 32'd0, 8'hC3, 1'b1);
    send(32'h1234_5681, 32'd4, 8'h7E, 1'b1);

    // start while busy is ignored
    send(32'h0000_00A5, 32'd1, 8'h66, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.tx_word = 32'hFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_during_ignored", {30'h0, bus.rd_word[31:30]}, 32'd2);

    // start coinciding with TAIL completion is ignored
    send(32'h0000_0033, 32'd2, 8'h99, 1'b1);
    repeat ((2 * F + 1) * 2 - 1) @(posedge clk);
    #1;
    bus.tx_word = 32'h0000_00F0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("tail_start_busy", {31'h0, bus.rd_word[31]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("tail_start_cs_n", {31'h0, bus.cs_n}, 32'd1);
    chk("tail_start_rd", bus.rd_word, 32'h4000_0099);

    // async reset at the 4th SCLK rise
    send(32'h0000_00A5, 32'd2, 8'h5A, 1'b0);
    nr = 0; ps = 1'b0; t = 0;
    while (nr < 4 && t < 300) begin
      @(posedge clk); #1; t++;
      if (bus.sclk && !ps) nr++;
      ps = bus.sclk;
    end
    chk("reached_edge4", nr, 4);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", {31'h0, bus.cs_n}, 32'd1);
    chk("midrst_sclk", {31'h0, bus.sclk}, 32'd0);
    chk("midrst_rd_word", bus.rd_word, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'h0000_00C3, 32'd1, 8'h96, 1'b1);

    // divider change mid-frame only affects the next frame
    send(32'h0000_00A5, 32'd1, 8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.clkdiv = 32'd8;
    send(32'h0000_005A, 32'd8, 8'h81, 1'b1);

    for (int i = 0; i < 20; i++) begin
      send($urandom, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 5),
           8'($urandom), 1'b1);
    end

    t = 0;
    while (exq.size() > 0 && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (exq.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d frames outstanding expected 0", exq.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
